// File: rtl/mips_mem_loader.sv
// Byte-stream program/data loader for the MIPS-Lite CPU.
// Parses command frames, writes bytes into instruction or data memory,
// and holds the CPU in reset until a run command arrives.
module mips_mem_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              load_done,
  output logic [7:0]        checksum,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_A_HI, S_A_LO, S_L_HI, S_L_LO, S_DATA, S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        hdr_hi_q, hdr_hi_d;
  logic [15:0]       rem_q, rem_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              load_done_q, load_done_d;
  logic [7:0]        checksum_q, checksum_d;
  logic              err_q, err_d;

  logic              fire;
  logic [15:0]       hdr_word;

  assign fire     = in_valid && in_ready_q;
  // High header byte is shared by the address and length fields.
  assign hdr_word = {hdr_hi_q, in_data};

  // Next-state and output computation for the frame parser.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b1;
    mem_we_d    = 1'b0;
    sel_d       = sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    addr_d      = addr_q;
    hdr_hi_d    = hdr_hi_q;
    rem_d       = rem_q;
    cpu_rst_d   = cpu_rst_q;
    load_done_d = 1'b0;
    checksum_d  = checksum_q;
    err_d       = err_q;
    if (fire) begin
      unique case (state_q)
        S_IDLE, S_RUN: begin
          unique case (in_data)
            8'h01, 8'h02: begin
              sel_d      = in_data[1];
              checksum_d = '0;
              cpu_rst_d  = 1'b1;
              state_d    = S_A_HI;
            end
            8'h03: begin
              cpu_rst_d = 1'b0;
              state_d   = S_RUN;
            end
            8'h04: begin
              cpu_rst_d = 1'b1;
              state_d   = S_IDLE;
            end
            default: err_d = 1'b1;
          endcase
        end
        S_A_HI: begin
          hdr_hi_d = in_data;
          state_d  = S_A_LO;
        end
        S_A_LO: begin
          addr_d  = hdr_word[ADDR_W-1:0];
          state_d = S_L_HI;
        end
        S_L_HI: begin
          hdr_hi_d = in_data;
          state_d  = S_L_LO;
        end
        S_L_LO: begin
          if (hdr_word == 16'd0) begin
            load_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            rem_d   = hdr_word;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = in_data;
          addr_d      = addr_q + ADDR_W'(1);
          checksum_d  = checksum_q + in_data;
          rem_d       = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            load_done_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      sel_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      addr_q      <= '0;
      hdr_hi_q    <= '0;
      rem_q       <= '0;
      cpu_rst_q   <= 1'b1;
      load_done_q <= 1'b0;
      checksum_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      sel_q       <= sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      addr_q      <= addr_d;
      hdr_hi_q    <= hdr_hi_d;
      rem_q       <= rem_d;
      cpu_rst_q   <= cpu_rst_d;
      load_done_q <= load_done_d;
      checksum_q  <= checksum_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_sel   = sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_RUN);
  assign load_done = load_done_q;
  assign checksum  = checksum_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mips_mem_loader.sv
// Scoreboard bench for mips_mem_loader: stimulus pushes expected write /
// done events, a negedge monitor pops and compares them.
module tb_mips_mem_loader;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              load_done;
  logic [7:0]        checksum;
  logic              err;

  typedef struct packed {
    logic              we;
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              done;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  mips_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
    .busy(busy), .load_done(load_done), .checksum(checksum), .err(err)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_wr(input logic sel, input logic [ADDR_W-1:0] a,
                         input logic [7:0] d, input logic done);
    exp_q.push_back('{we: 1'b1, sel: sel, addr: a, data: d, done: done});
  endtask

  task automatic push_done_only();
    exp_q.push_back('{we: 1'b0, sel: 1'b0, addr: '0, data: '0, done: 1'b1});
  endtask

  // Drive one byte; in_ready is always 1 outside reset, so it transfers on the next edge.
  task automatic send(input logic [7:0] b, input int unsigned gap);
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every strobe/done event against the scoreboard.
  always @(negedge clk) begin
    if (!rst && (mem_we || load_done)) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_event: we=%0b done=%0b addr=%0h data=%0h, expected none",
                 mem_we, load_done, mem_addr, mem_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ev_we", {31'd0, mem_we}, {31'd0, e.we});
        check("ev_done", {31'd0, load_done}, {31'd0, e.done});
        if (e.we) begin
          check("ev_sel", {31'd0, mem_sel}, {31'd0, e.sel});
          check("ev_addr", {22'd0, mem_addr}, {22'd0, e.addr});
          check("ev_data", {24'd0, mem_wdata}, {24'd0, e.data});
        end
      end
    end
  end

  initial begin
    // Reset values while rst is high.
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_checksum", {24'd0, checksum}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_addr", {22'd0, mem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Frame 1: instruction memory, 4 bytes at 0.
    push_wr(1'b0, 10'h000, 8'h20, 1'b0);
    push_wr(1'b0, 10'h001, 8'h00, 1'b0);
    push_wr(1'b0, 10'h002, 8'h00, 1'b0);
    push_wr(1'b0, 10'h003, 8'h00, 1'b1);
    send(8'h01, 0);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h04, 0);
    send(8'h20, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    idle(2);
    check("f1_checksum", {24'd0, checksum}, 32'h20);
    check("f1_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("f1_busy", {31'd0, busy}, 32'd0);

    // Frame 2: data memory at 0x10, then run.
    push_wr(1'b1, 10'h010, 8'hAA, 1'b0);
    push_wr(1'b1, 10'h011, 8'h55, 1'b1);
    send(8'h02, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 0); send(8'h02, 0);
    send(8'hAA, 0); send(8'h55, 0);
    idle(1);
    check("f2_checksum", {24'd0, checksum}, 32'hFF);
    send(8'h03, 0);
    check("run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    send(8'h03, 0);
    check("run_again_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    // Load from RUN halts the CPU; then halt command.
    push_wr(1'b0, 10'h000, 8'h99, 1'b1);
    send(8'h01, 0);
    check("run_load_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h01, 0);
    send(8'h99, 0);
    idle(1);
    check("run_load_checksum", {24'd0, checksum}, 32'h99);
    send(8'h04, 0);
    check("halt_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("halt_busy", {31'd0, busy}, 32'd0);

    // Address wrap with truncated upper bits.
    push_wr(1'b0, 10'h3FF, 8'h11, 1'b0);
    push_wr(1'b0, 10'h000, 8'h22, 1'b1);
    send(8'h01, 0); send(8'h03, 0); send(8'hFF, 0); send(8'h00, 0); send(8'h02, 0);
    send(8'h11, 0); send(8'h22, 0);
    idle(1);
    check("wrap_checksum", {24'd0, checksum}, 32'h33);

    // LEN = 0: done pulse only, busy low right after.
    push_done_only();
    send(8'h01, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    check("len0_busy", {31'd0, busy}, 32'd0);
    check("len0_checksum", {24'd0, checksum}, 32'h00);
    idle(2);

    // Unknown command sets sticky err.
    send(8'h7F, 0);
    check("err_set", {31'd0, err}, 32'd1);
    check("err_busy", {31'd0, busy}, 32'd0);

    // 16-byte load, gapless then with random gaps; data i*0x11+1, sum = 0x08.
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned i = 0; i < 16; i++)
        push_wr(1'b1, 10'(10'h100 + i), 8'(i * 8'h11 + 8'h01), i == 15);
      send(8'h02, 0); send(8'h01, 0); send(8'h00, 0); send(8'h00, 0); send(8'h10, 0);
      for (int unsigned i = 0; i < 16; i++)
        send(8'(i * 8'h11 + 8'h01), (pass == 0) ? 0 : $urandom_range(0, 1));
      idle(2);
      check("l16_checksum", {24'd0, checksum}, 32'h08);
    end
    check("err_sticky", {31'd0, err}, 32'd1);

    // Reset after the 8th data byte: 8th write is in flight and dropped.
    for (int unsigned i = 0; i < 7; i++)
      push_wr(1'b1, 10'(10'h100 + i), 8'(i * 8'h11 + 8'h01), 1'b0);
    send(8'h02, 0); send(8'h01, 0); send(8'h00, 0); send(8'h00, 0); send(8'h10, 0);
    for (int unsigned i = 0; i < 8; i++)
      send(8'(i * 8'h11 + 8'h01), 0);
    rst = 1'b1;
    #1;
    check("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("mid_rst_checksum", {24'd0, checksum}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_queue", exp_q.size(), 32'd0);
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    idle(20);

    // New frame after reset works normally.
    push_wr(1'b0, 10'h005, 8'h42, 1'b1);
    send(8'h01, 0); send(8'h00, 0); send(8'h05, 0); send(8'h00, 0); send(8'h01, 0);
    send(8'h42, 0);
    idle(3);
    check("post_rst_checksum", {24'd0, checksum}, 32'h42);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
